cond_exec_ctrl: RTL

- Execute-stage conditional-execution controller for the pipelined CPU control unit.
- Owns the architectural NZCV flags register and an E-stage control register (captured from decode, with stall and flush).
- Evaluates the instruction condition code against the current flags and gates PCS, RegW and MemW.
- Updates flags per FlagW and keeps saturating executed/annulled performance counters.

---
 rtl/cpu_ctrl_pkg.sv | 19 +
 rtl/cond_eval.sv | 39 +++
 rtl/cond_exec_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: condition codes and NZCV flag layout.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check of a 4-bit cond against {N,Z,C,V}.
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v, ge;

  always_comb begin
    n    = flags[N_IDX];
    z    = flags[Z_IDX];
    c    = flags[C_IDX];
    v    = flags[V_IDX];
    ge   = (n == v);
    pass = 1'b0;
    case (cond)
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~(c & ~z);
      GE: pass = ge;
      LT: pass = ~ge;
      GT: pass = ~z & ge;
      LE: pass = ~(~z & ge);
      AL: pass = 1'b1;
      default: pass = 1'b0;  // NV never executes
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// E-stage conditional-execution controller: E control register, NZCV flags,
// condition gating of PCS/RegW/MemW and saturating executed/annulled counters.
module cond_exec_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int         CNT_W     = 16,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_d,
  input  logic [3:0]       cond_d,
  input  logic [1:0]       flag_w_d,
  input  logic             pcs_d,
  input  logic             reg_w_d,
  input  logic             mem_w_d,
  input  logic             no_write_d,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [3:0]       alu_flags_e,
  output logic             cond_ex_e,
  output logic             pcs_e,
  output logic             reg_w_e,
  output logic             mem_w_e,
  output logic             branch_taken_e,
  output logic             illegal_cond_e,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] annul_cnt
);

  logic             valid_e_q, valid_e_d;
  logic [3:0]       cond_e_q, cond_e_d;
  logic [1:0]       flag_w_e_q, flag_w_e_d;
  logic             pcs_e_q, pcs_e_d;
  logic             reg_w_e_q, reg_w_e_d;
  logic             mem_w_e_q, mem_w_e_d;
  logic             no_write_e_q, no_write_e_d;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] annul_cnt_q, annul_cnt_d;
  logic             cond_pass;

  cond_eval u_cond_eval (
    .cond  (cond_e_q),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    cond_ex_e      = valid_e_q & cond_pass;
    pcs_e          = pcs_e_q & cond_ex_e;
    reg_w_e        = reg_w_e_q & cond_ex_e & ~no_write_e_q;
    mem_w_e        = mem_w_e_q & cond_ex_e;
    branch_taken_e = pcs_e;
    illegal_cond_e = valid_e_q & (cond_e_q == NV);
    exec_cnt       = exec_cnt_q;
    annul_cnt      = annul_cnt_q;
  end

  // Flush only kills the incoming instruction; the outgoing one still retires
  // unless a stall holds it in E.
  always_comb begin
    valid_e_d    = valid_e_q;
    cond_e_d     = cond_e_q;
    flag_w_e_d   = flag_w_e_q;
    pcs_e_d      = pcs_e_q;
    reg_w_e_d    = reg_w_e_q;
    mem_w_e_d    = mem_w_e_q;
    no_write_e_d = no_write_e_q;
    flags_d      = flags_q;
    exec_cnt_d   = exec_cnt_q;
    annul_cnt_d  = annul_cnt_q;

    if (flush_e) begin
      valid_e_d = 1'b0;
    end else if (!stall_e) begin
      valid_e_d    = valid_d;
      cond_e_d     = cond_d;
      flag_w_e_d   = flag_w_d;
      pcs_e_d      = pcs_d;
      reg_w_e_d    = reg_w_d;
      mem_w_e_d    = mem_w_d;
      no_write_e_d = no_write_d;
    end

    if (!stall_e && cond_ex_e) begin
      if (flag_w_e_q[FLAGW_NZ]) begin
        flags_d[N_IDX] = alu_flags_e[N_IDX];
        flags_d[Z_IDX] = alu_flags_e[Z_IDX];
      end
      if (flag_w_e_q[FLAGW_CV]) begin
        flags_d[C_IDX] = alu_flags_e[C_IDX];
        flags_d[V_IDX] = alu_flags_e[V_IDX];
      end
    end

    if (!stall_e && valid_e_q) begin
      if (cond_ex_e) begin
        if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + CNT_W'(1);
      end else begin
        if (annul_cnt_q != '1) annul_cnt_d = annul_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_e_q    <= 1'b0;
      cond_e_q     <= 4'b0000;
      flag_w_e_q   <= 2'b00;
      pcs_e_q      <= 1'b0;
      reg_w_e_q    <= 1'b0;
      mem_w_e_q    <= 1'b0;
      no_write_e_q <= 1'b0;
      flags_q      <= FLAGS_RST;
      exec_cnt_q   <= '0;
      annul_cnt_q  <= '0;
    end else begin
      valid_e_q    <= valid_e_d;
      cond_e_q     <= cond_e_d;
      flag_w_e_q   <= flag_w_e_d;
      pcs_e_q      <= pcs_e_d;
      reg_w_e_q    <= reg_w_e_d;
      mem_w_e_q    <= mem_w_e_d;
      no_write_e_q <= no_write_e_d;
      flags_q      <= flags_d;
      exec_cnt_q   <= exec_cnt_d;
      annul_cnt_q  <= annul_cnt_d;
    end
  end

endmodule
